// File: rtl/char_scroll_encoder_pkg.sv
// Shared character codes and scroll-FSM state encodings for the HEX scroller
// and its per-digit character decoders.
package char_codes;

   // 2-bit character codes shown on each HEX digit
   typedef enum logic [1:0] {
      CH_D     = 2'b00,
      CH_E     = 2'b01,
      CH_ONE   = 2'b10,
      CH_BLANK = 2'b11
   } char_t;

   // Scroll controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   localparam int CHAR_W = 2;

   // Width of the counter inside tick_gen; covers TICK_DIV up to 2^26-1
   localparam int TICK_CNT_W = 26;

endpackage

// File: rtl/char_scroll_encoder_if.sv
// Bundle of the scroller's control and display signals; the master side
// drives load/run/dir/step, the slave side (the scroller) returns codes/tick/busy.
interface char_scroll_encoder_if #(
   parameter int NUM_DISP = 6
);
   logic                    load;
   logic [2*NUM_DISP-1:0]   load_data;
   logic                    run;
   logic                    dir;
   logic                    step;
   logic [2*NUM_DISP-1:0]   codes;
   logic                    tick;
   logic                    busy;

   modport master (
      output load, load_data, run, dir, step,
      input  codes, tick, busy
   );

   modport slave (
      input  load, load_data, run, dir, step,
      output codes, tick, busy
   );
endinterface

// File: rtl/char_scroll_encoder_tick_gen.sv
// Free-running scroll-tick divider: counts 0..TICK_DIV-1 and strobes tick
// during the terminal count.
module tick_gen
   import char_codes::*;
#(
   parameter int TICK_DIV = 25000000
) (
   input  logic CLOCK_50,
   input  logic Reset,
   output logic tick
);

   localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(TICK_DIV - 1);

   logic [TICK_CNT_W-1:0] cnt_q;
   logic [TICK_CNT_W-1:0] cnt_d;

   // Next count: wrap to zero after the terminal count
   always_comb begin
      cnt_d = cnt_q + TICK_CNT_W'(1);
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/char_scroll_encoder.sv
// Six-slot character scroller: loads 2-bit char codes and rotates them left
// or right on each divider tick (when running) or each debounced-free step edge.
module char_scroll_encoder
   import char_codes::*;
#(
   parameter int TICK_DIV = 25000000,
   parameter int NUM_DISP = 6
) (
   input  logic                  CLOCK_50,
   input  logic                  Reset,
   input  logic                  load,
   input  logic [2*NUM_DISP-1:0] load_data,
   input  logic                  run,
   input  logic                  dir,
   input  logic                  step,
   output logic [2*NUM_DISP-1:0] codes,
   output logic                  tick,
   output logic                  busy
);

   localparam int W = CHAR_W * NUM_DISP;
   localparam logic [W-1:0] BLANK_ALL = {NUM_DISP{CH_BLANK}};

   state_t         state_q, state_d;
   logic           busy_q, busy_d;
   logic [W-1:0]   codes_q, codes_d;
   logic           step_s1_q, step_s1_d;
   logic           step_s2_q, step_s2_d;
   logic           step_s3_q, step_s3_d;
   logic           step_edge;
   logic           rot_req;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .Reset    (Reset),
      .tick     (tick)
   );

   // Two-flop synchroniser plus one history flop for rising-edge detection
   always_comb begin
      step_s1_d = step;
      step_s2_d = step_s1_q;
      step_s3_d = step_s2_q;
   end

   assign step_edge = step_s2_q & ~step_s3_q;

   // Next state, busy flag and slot contents; load beats rotation, and a tick
   // coinciding with a step edge still yields a single rotation
   always_comb begin
      state_d = run ? ST_RUN : ST_IDLE;
      if (load) begin
         state_d = ST_HOLD;
      end
      busy_d  = (state_d == ST_RUN);

      rot_req = (state_q != ST_HOLD) &&
                (step_edge || ((state_q == ST_RUN) && tick));

      codes_d = codes_q;
      if (load) begin
         codes_d = load_data;
      end else if (rot_req) begin
         if (dir) begin
            codes_d = {codes_q[CHAR_W-1:0], codes_q[W-1:CHAR_W]};
         end else begin
            codes_d = {codes_q[W-CHAR_W-1:0], codes_q[W-1:W-CHAR_W]};
         end
      end
   end

   // Step synchroniser registers
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         step_s1_q <= 1'b0;
         step_s2_q <= 1'b0;
         step_s3_q <= 1'b0;
      end else begin
         step_s1_q <= step_s1_d;
         step_s2_q <= step_s2_d;
         step_s3_q <= step_s3_d;
      end
   end

   // FSM state with registered busy and slot outputs
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         codes_q <= BLANK_ALL;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         codes_q <= codes_d;
      end
   end

   assign codes = codes_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_char_scroll_encoder.sv
// Directed bench for char_scroll_encoder with TICK_DIV=4.
module tb_char_scroll_encoder;

   logic CLOCK_50 = 1'b0;
   logic Reset;

   always #5 CLOCK_50 = ~CLOCK_50;

   char_scroll_encoder_if #(.NUM_DISP(6)) bus ();

   char_scroll_encoder #(
      .TICK_DIV (4),
      .NUM_DISP (6)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .Reset     (Reset),
      .load      (bus.load),
      .load_data (bus.load_data),
      .run       (bus.run),
      .dir       (bus.dir),
      .step      (bus.step),
      .codes     (bus.codes),
      .tick      (bus.tick),
      .busy      (bus.busy)
   );

   typedef struct {
      logic        load;
      logic [11:0] data;
      logic        run;
      logic        dir;
      logic [11:0] exp_codes;
      logic        exp_tick;
      logic        exp_busy;
   } vec_t;

   vec_t        vecs [64];
   logic [11:0] rot_seq [7];
   int          chk_cnt  = 0;
   int          pass_cnt = 0;

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int e;

      // left-rotation sequence of 12'h1B6, worked out by hand
      rot_seq[0] = 12'h1B6;
      rot_seq[1] = 12'h6D8;
      rot_seq[2] = 12'hB61;
      rot_seq[3] = 12'hD86;
      rot_seq[4] = 12'h61B;
      rot_seq[5] = 12'h86D;
      rot_seq[6] = 12'h1B6;

      // rows 0..39: load then idle; rows 40..63: auto-scroll left
      for (int i = 0; i < 64; i++) begin
         e = i + 1;
         vecs[i].load      = (i == 0);
         vecs[i].data      = 12'h1B6;
         vecs[i].run       = (i >= 40);
         vecs[i].dir       = 1'b0;
         vecs[i].exp_tick  = ((e % 4) == 3);
         vecs[i].exp_busy  = (i >= 40);
         vecs[i].exp_codes = (i < 40) ? 12'h1B6 : rot_seq[(e - 40) / 4];
      end

      Reset         = 1'b1;
      bus.load      = 1'b0;
      bus.load_data = '0;
      bus.run       = 1'b0;
      bus.dir       = 1'b0;
      bus.step      = 1'b0;
      cyc();
      cyc();
      chk("reset codes", bus.codes, 12'hFFF);
      chk("reset busy", {11'b0, bus.busy}, 12'h000);
      chk("reset tick", {11'b0, bus.tick}, 12'h000);
      Reset = 1'b0;

      for (int i = 0; i < 64; i++) begin
         bus.load      = vecs[i].load;
         bus.load_data = vecs[i].data;
         bus.run       = vecs[i].run;
         bus.dir       = vecs[i].dir;
         cyc();
         chk($sformatf("vec%0d codes", i), bus.codes, vecs[i].exp_codes);
         chk($sformatf("vec%0d tick", i), {11'b0, bus.tick}, {11'b0, vecs[i].exp_tick});
         chk($sformatf("vec%0d busy", i), {11'b0, bus.busy}, {11'b0, vecs[i].exp_busy});
      end

      // tick and step edge in the same RUN cycle, rotating right
      bus.dir = 1'b1;
      cyc();
      chk("pre-step codes", bus.codes, 12'h1B6);
      bus.step = 1'b1;
      cyc();
      cyc();
      chk("coincide tick", {11'b0, bus.tick}, 12'h001);
      chk("coincide before", bus.codes, 12'h1B6);
      cyc();
      chk("coincide single rot", bus.codes, 12'h86D);
      cyc();
      cyc();
      cyc();
      chk("held step no rot", bus.codes, 12'h86D);
      chk("next tick", {11'b0, bus.tick}, 12'h001);
      cyc();
      chk("tick rot right", bus.codes, 12'h61B);
      bus.step = 1'b0;

      // load during a tick cycle: load wins, one HOLD cycle, then RUN
      cyc();
      cyc();
      cyc();
      chk("tick before load", {11'b0, bus.tick}, 12'h001);
      bus.load      = 1'b1;
      bus.load_data = 12'h2C4;
      cyc();
      chk("load over tick", bus.codes, 12'h2C4);
      chk("hold busy", {11'b0, bus.busy}, 12'h000);
      bus.load = 1'b0;
      cyc();
      chk("hold->run busy", {11'b0, bus.busy}, 12'h001);
      chk("after hold codes", bus.codes, 12'h2C4);

      // reset mid-RUN overrides load/run/step
      cyc();
      Reset         = 1'b1;
      bus.load      = 1'b1;
      bus.load_data = 12'h000;
      bus.step      = 1'b1;
      cyc();
      chk("mid reset codes", bus.codes, 12'hFFF);
      chk("mid reset busy", {11'b0, bus.busy}, 12'h000);
      chk("mid reset tick", {11'b0, bus.tick}, 12'h000);
      Reset    = 1'b0;
      bus.load = 1'b0;
      bus.run  = 1'b0;
      bus.step = 1'b0;
      cyc();
      chk("post reset tick1", {11'b0, bus.tick}, 12'h000);
      cyc();
      chk("post reset tick2", {11'b0, bus.tick}, 12'h000);
      cyc();
      chk("post reset tick3", {11'b0, bus.tick}, 12'h001);
      chk("post reset codes", bus.codes, 12'hFFF);

      // step held high in IDLE: one left rotation, 3 cycles after the edge
      bus.dir       = 1'b0;
      bus.load      = 1'b1;
      bus.load_data = 12'h1B6;
      cyc();
      bus.load = 1'b0;
      cyc();
      cyc();
      bus.step = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk($sformatf("step hold %0d", k), bus.codes, (k >= 3) ? 12'h6D8 : 12'h1B6);
      end
      chk("step idle busy", {11'b0, bus.busy}, 12'h000);
      bus.step = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
